clock_display_scan: RTL and testbench

//   Downstream of ClockModule: consumes binary hr/min/sec and drives a 6-digit

---
 rtl/clock_disp_pkg.sv | 50 +++++
 rtl/bin2bcd_60.sv | 26 ++
 rtl/clock_display_scan.sv | 145 ++++++++++++++
 tb/tb_clock_display_scan.sv | 138 +++++++++++++
 4 files changed

// File: rtl/clock_disp_pkg.sv
// Shared constants for the multiplexed HH.MM.SS display: segment codes,
// edit-field encoding and digit scan positions.
package clock_disp_pkg;

  // Segment patterns {g,f,e,d,c,b,a}, active-high (common cathode)
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Field under edit
  localparam logic [1:0] FIELD_SEC  = 2'd0;
  localparam logic [1:0] FIELD_MIN  = 2'd1;
  localparam logic [1:0] FIELD_HR   = 2'd2;
  localparam logic [1:0] FIELD_NONE = 2'd3;

  // Scan positions, rightmost digit first
  localparam logic [2:0] IDX_SEC_ONES = 3'd0;
  localparam logic [2:0] IDX_SEC_TENS = 3'd1;
  localparam logic [2:0] IDX_MIN_ONES = 3'd2;
  localparam logic [2:0] IDX_MIN_TENS = 3'd3;
  localparam logic [2:0] IDX_HR_ONES  = 3'd4;
  localparam logic [2:0] IDX_HR_TENS  = 3'd5;

  // Decimal digit to segment pattern; anything above 9 renders as a dash
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = SEG_0;
      4'd1:    seg_of = SEG_1;
      4'd2:    seg_of = SEG_2;
      4'd3:    seg_of = SEG_3;
      4'd4:    seg_of = SEG_4;
      4'd5:    seg_of = SEG_5;
      4'd6:    seg_of = SEG_6;
      4'd7:    seg_of = SEG_7;
      4'd8:    seg_of = SEG_8;
      4'd9:    seg_of = SEG_9;
      default: seg_of = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_60.sv
// Combinational 0..59 binary to two-digit BCD using compares and constant
// subtraction only. invalid flags values at or above LIMIT.
module bin2bcd_60 #(
  parameter int LIMIT = 60
) (
  input  logic [5:0] value,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       invalid
);

  // Pick the largest multiple of ten not exceeding value; the ones digit
  // only depends on the low nibble because the result is below 16.
  always_comb begin
    tens    = 4'd0;
    ones    = value[3:0];
    invalid = (value >= 6'(LIMIT));
    for (int k = 1; k <= 5; k++) begin
      if (value >= 6'(10 * k)) begin
        tens = 4'(k);
        ones = value[3:0] - 4'((10 * k) % 16);
      end
    end
  end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed HH.MM.SS driver. Time and edit state are captured
// once per frame so a scan never mixes old and new values; the edited field
// blinks while set mode is active.
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [4:0] i_hr,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic       i_set,
  input  logic [1:0] i_field,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic [5:0] o_digit_en
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_ph;
  logic               first;
  logic [4:0]         snap_hr;
  logic [5:0]         snap_min;
  logic [5:0]         snap_sec;
  logic               snap_set;
  logic [1:0]         snap_field;

  logic scan_wrap;
  logic frame_end;
  assign scan_wrap = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign frame_end = scan_wrap && (idx == IDX_HR_TENS);

  logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
  logic       hr_bad, min_bad, sec_bad;

  bin2bcd_60 #(.LIMIT(24)) u_hr (
    .value({1'b0, snap_hr}), .tens(hr_tens), .ones(hr_ones), .invalid(hr_bad)
  );
  bin2bcd_60 #(.LIMIT(60)) u_min (
    .value(snap_min), .tens(min_tens), .ones(min_ones), .invalid(min_bad)
  );
  bin2bcd_60 #(.LIMIT(60)) u_sec (
    .value(snap_sec), .tens(sec_tens), .ones(sec_ones), .invalid(sec_bad)
  );

  // Digit dwell counter and digit position
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      scan_cnt <= '0;
      idx      <= IDX_SEC_ONES;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_HR_TENS) ? IDX_SEC_ONES : idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Free-running blink timebase; phase flips every BLINK_DIV cycles
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Capture inputs on the first edge after reset and at every frame end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      first      <= 1'b1;
      snap_hr    <= '0;
      snap_min   <= '0;
      snap_sec   <= '0;
      snap_set   <= 1'b0;
      snap_field <= FIELD_SEC;
    end else begin
      first <= 1'b0;
      if (first || frame_end) begin
        snap_hr    <= i_hr;
        snap_min   <= i_min;
        snap_sec   <= i_sec;
        snap_set   <= i_set;
        snap_field <= i_field;
      end
    end
  end

  logic [3:0] digit;
  logic       digit_bad;
  logic [1:0] digit_field;
  logic       blank;
  logic [6:0] seg_next;
  logic       dp_next;
  logic [5:0] en_next;

  // Select the digit for the current position and apply dash/blink rules
  always_comb begin
    digit       = 4'd0;
    digit_bad   = 1'b0;
    digit_field = FIELD_NONE;
    case (idx)
      IDX_SEC_ONES: begin digit = sec_ones; digit_bad = sec_bad; digit_field = FIELD_SEC; end
      IDX_SEC_TENS: begin digit = sec_tens; digit_bad = sec_bad; digit_field = FIELD_SEC; end
      IDX_MIN_ONES: begin digit = min_ones; digit_bad = min_bad; digit_field = FIELD_MIN; end
      IDX_MIN_TENS: begin digit = min_tens; digit_bad = min_bad; digit_field = FIELD_MIN; end
      IDX_HR_ONES:  begin digit = hr_ones;  digit_bad = hr_bad;  digit_field = FIELD_HR;  end
      IDX_HR_TENS:  begin digit = hr_tens;  digit_bad = hr_bad;  digit_field = FIELD_HR;  end
      default: ;
    endcase
    blank = snap_set && blink_ph && (snap_field != FIELD_NONE) &&
            (snap_field == digit_field);
    if (blank)          seg_next = SEG_OFF;
    else if (digit_bad) seg_next = SEG_DASH;
    else                seg_next = seg_of(digit);
    dp_next = (idx == IDX_MIN_ONES) || (idx == IDX_HR_ONES);
    en_next = 6'd1 << idx;
  end

  // Registered display outputs, one cycle behind the scan position
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_seg      <= SEG_OFF;
      o_dp       <= 1'b0;
      o_digit_en <= 6'b0;
    end else begin
      o_seg      <= seg_next;
      o_dp       <= dp_next;
      o_digit_en <= en_next;
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan with SCAN_DIV=4, BLINK_DIV=64.
// Edge n counts rising edges since reset release; the outputs after edge n
// show digit ((n-1)/4)%6, snapshots load at edge 1 and every 24th edge, and
// blink phase is 1 for outputs after edges 65..128 and 193..256.
module tb_clock_display_scan;

  logic       clk;
  logic       rstn;
  logic [4:0] hr;
  logic [5:0] min;
  logic [5:0] sec;
  logic       set;
  logic [1:0] field;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] digit_en;

  int n_cmp;
  int n_err;
  int edge_n;

  clock_display_scan #(.SCAN_DIV(4), .BLINK_DIV(64)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_hr(hr), .i_min(min), .i_sec(sec),
    .i_set(set), .i_field(field), .o_seg(seg), .o_dp(dp), .o_digit_en(digit_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("edge %0d %s observed=%0h expected=%0h", edge_n, tag, obs, exp);
  endtask

  // Advance to just after rising edge n (bounded by n)
  task automatic run_to(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  // Check all three outputs after edge n
  task automatic chk_all(input string tag, input int n, input logic [6:0] exp_seg,
                         input logic exp_dp, input logic [5:0] exp_en);
    run_to(n);
    chk({tag, "_seg"}, {25'd0, seg}, {25'd0, exp_seg});
    chk({tag, "_dp"},  {31'd0, dp},  {31'd0, exp_dp});
    chk({tag, "_en"},  {26'd0, digit_en}, {26'd0, exp_en});
  endtask

  logic [6:0] frame1 [6];
  int d;

  initial begin
    n_cmp = 0;
    n_err = 0;
    edge_n = 0;
    frame1[0] = 7'h7D; frame1[1] = 7'h6D; frame1[2] = 7'h66;
    frame1[3] = 7'h4F; frame1[4] = 7'h5B; frame1[5] = 7'h06;
    hr = 5'd12; min = 6'd34; sec = 6'd56; set = 1'b0; field = 2'd3;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", {25'd0, seg}, 32'h0);
    chk("rst_dp",  {31'd0, dp}, 32'h0);
    chk("rst_en",  {26'd0, digit_en}, 32'h0);

    // Release; first edge shows reset snapshot (all zero) at digit 0
    @(negedge clk);
    rstn = 1'b1;
    edge_n = 0;
    chk_all("first", 1, 7'h3F, 1'b0, 6'b000001);

    // Frame 1 shows 12.34.56 captured at edge 1
    for (int n = 2; n <= 24; n++) begin
      d = ((n - 1) / 4) % 6;
      if (n == 21) sec = 6'd59;          // lands in snapshot at edge 24
      chk_all("f1", n, frame1[d], (d == 2) || (d == 4), 6'd1 << d);
    end

    // Frame 2: sec=59; change inputs mid-digit-0, must not appear this frame
    chk_all("f2_s1", 25, 7'h6F, 1'b0, 6'b000001);
    run_to(26);
    sec = 6'd0; set = 1'b1; field = 2'd1;
    chk_all("f2_s1_hold", 28, 7'h6F, 1'b0, 6'b000001);
    chk_all("f2_s10", 29, 7'h6D, 1'b0, 6'b000010);
    chk_all("f2_m1", 33, 7'h66, 1'b1, 6'b000100);

    // Frame 3: sec=00 now visible; set on minutes but blink phase still 0
    chk_all("f3_s1", 49, 7'h3F, 1'b0, 6'b000001);
    chk_all("f3_s10", 53, 7'h3F, 1'b0, 6'b000010);
    chk_all("f3_m1_ph0", 57, 7'h66, 1'b1, 6'b000100);
    chk_all("f3_h1_ph1", 65, 7'h5B, 1'b1, 6'b010000);

    // Frame 4: blink phase 1, minutes blanked, scanning continues
    chk_all("f4_s1", 73, 7'h3F, 1'b0, 6'b000001);
    chk_all("f4_m1_blank", 81, 7'h00, 1'b1, 6'b000100);
    chk_all("f4_m10_blank", 85, 7'h00, 1'b0, 6'b001000);
    chk_all("f4_h1", 89, 7'h5B, 1'b1, 6'b010000);
    hr = 5'd25; field = 2'd3;

    // Frame 5: field none -> no blanking; hr=25 shows dashes
    chk_all("f5_s1", 97, 7'h3F, 1'b0, 6'b000001);
    chk_all("f5_m1_none", 105, 7'h66, 1'b1, 6'b000100);
    chk_all("f5_m10", 109, 7'h4F, 1'b0, 6'b001000);
    chk_all("f5_h1_dash", 113, 7'h40, 1'b1, 6'b010000);
    chk_all("f5_h10_dash", 117, 7'h40, 1'b0, 6'b100000);
    set = 1'b0; field = 2'd1;

    // Frame 9 (blink phase 1 again): set off -> minutes not blanked
    chk_all("f9_m1_noset", 201, 7'h66, 1'b1, 6'b000100);

    // Asynchronous reset mid-scan clears outputs without a clock edge
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_seg", {25'd0, seg}, 32'h0);
    chk("mid_rst_dp",  {31'd0, dp}, 32'h0);
    chk("mid_rst_en",  {26'd0, digit_en}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    edge_n = 0;
    chk_all("rst2_first", 1, 7'h3F, 1'b0, 6'b000001);
    chk_all("rst2_hold", 4, 7'h3F, 1'b0, 6'b000001);
    chk_all("rst2_s10", 5, 7'h3F, 1'b0, 6'b000010);
    chk_all("rst2_h1", 17, 7'h40, 1'b1, 6'b010000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
